// File: rtl/prores_scan_pkg.sv
// Shared constants for the ProRes slice coefficient scanner: memory geometry,
// FSM encodings and the two 64-entry zigzag tables (progressive / interlaced).
package prores_scan_pkg;

  localparam int MEM_WORDS   = 2048;
  localparam int BLOCK_WORDS = 64;
  localparam int MAX_BLOCKS  = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DC    = 2'd1;
  localparam logic [1:0] S_AC    = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_DC    = S_DC,
    ST_AC    = S_AC,
    ST_FLUSH = S_FLUSH
  } scan_state_e;

  localparam logic [5:0] SCAN_PROG [BLOCK_WORDS] = '{
     0,  1,  8,  9,  2,  3, 10, 11,
    16, 17, 24, 25, 18, 19, 26, 27,
     4,  5, 12, 20, 13,  6,  7, 14,
    21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42,
    49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] SCAN_INTL [BLOCK_WORDS] = '{
     0,  8,  1,  9, 16, 24, 17, 25,
     2, 10,  3, 11, 18, 26, 19, 27,
    32, 40, 33, 34, 41, 48, 56, 49,
    42, 35, 43, 50, 57, 58, 51, 59,
     4, 12,  5,  6, 13, 20, 28, 21,
    14,  7, 15, 22, 29, 36, 44, 37,
    30, 23, 31, 38, 45, 52, 60, 53,
    46, 39, 47, 54, 61, 62, 55, 63
  };

endpackage

// File: rtl/coef_scan_addr.sv
// Maps (block index, scan position) to an 11-bit coefficient word address, combinational.
// SCAN_INTERLACED_EN selects the interlaced zigzag table; default is progressive.
module coef_scan_addr
  import prores_scan_pkg::*;
(
  input  logic [4:0]  blk,
  input  logic [5:0]  pos,
  output logic [10:0] addr
);

  logic [5:0] raster;

  always_comb begin
`ifdef SCAN_INTERLACED_EN
    raster = SCAN_INTL[pos];
`else
    raster = SCAN_PROG[pos];
`endif
  end

  // Block base is b*64, so the raster index simply fills the low six bits.
  assign addr = {blk, raster};

endmodule

// File: rtl/slice_coef_scanner.sv
// Streams a slice's coefficients in interleaved zigzag order (all DCs, then AC per position); first beat 1 cycle after start.
// Beats advance only on out_valid&&out_ready, holding outputs otherwise; SCAN_INTERLACED_EN picks the interlaced table.
module slice_coef_scanner
  import prores_scan_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  block_num,
  input  logic [31:0] input_data [MEM_WORDS],
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_dc,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  logic [1:0]  state;
  logic [4:0]  blk;
  logic [5:0]  pos;
  logic [4:0]  last_blk;

  logic        start_ok;
  logic        fire;
  logic        blk_wrap;
  logic [4:0]  nxt_blk;
  logic [5:0]  nxt_pos;
  logic [4:0]  a_blk;
  logic [5:0]  a_pos;
  logic [10:0] rd_addr;

  assign start_ok = (state == S_IDLE) && start && (block_num != 6'd0)
                    && (int'(block_num) <= MAX_BLOCKS);
  assign fire     = out_valid && out_ready;
  assign blk_wrap = (blk == last_blk);
  assign nxt_blk  = blk_wrap ? 5'd0 : blk + 5'd1;
  assign nxt_pos  = blk_wrap ? pos + 6'd1 : pos;

  // The address generator looks one beat ahead so out_data can be registered.
  assign a_blk = (state == S_IDLE) ? 5'd0 : nxt_blk;
  assign a_pos = (state == S_IDLE) ? 6'd0 : nxt_pos;

  coef_scan_addr u_addr (
    .blk  (a_blk),
    .pos  (a_pos),
    .addr (rd_addr)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_FLUSH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      blk       <= 5'd0;
      pos       <= 6'd0;
      last_blk  <= 5'd0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      out_is_dc <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state     <= S_DC;
            blk       <= 5'd0;
            pos       <= 6'd0;
            last_blk  <= 5'(block_num - 6'd1);
            out_data  <= input_data[rd_addr];
            out_valid <= 1'b1;
            out_is_dc <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        S_DC, S_AC: begin
          if (fire) begin
            if (out_last) begin
              state     <= S_FLUSH;
              blk       <= 5'd0;
              pos       <= 6'd0;
              out_valid <= 1'b0;
              out_is_dc <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              blk       <= nxt_blk;
              pos       <= nxt_pos;
              out_data  <= input_data[rd_addr];
              out_is_dc <= (nxt_pos == 6'd0);
              out_last  <= (nxt_blk == last_blk) && (nxt_pos == 6'd63);
              if ((state == S_DC) && (nxt_pos == 6'd1)) begin
                state <= S_AC;
              end
            end
          end
        end
        S_FLUSH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/slice_coef_scanner.md
SLICE_COEF_SCANNER -- requirements
Module: slice_coef_scanner

Interface
REQ-001 The module SHALL have the following ports, clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset (0 reset, 1 not reset).
- start  in  1  one-cycle request to scan a slice.
- block_num  in  6  number of 8x8 blocks in the slice, legal range 1..32.
- input_data  in  32 x [2048]  coefficient memory; block b, raster index r is at word b*64+r.
- out_data  out  32  coefficient being presented.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat when out_valid is also 1.
- out_is_dc  out  1  the current beat is a DC coefficient (scan position 0).
- out_last  out  1  the current beat is the final beat of the slice.
- busy  out  1  a scan is in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

Function
REQ-002 The module SHALL implement the states IDLE, DC, AC and FLUSH.
REQ-003 In IDLE, the module SHALL sample block_num and enter DC on the next edge when start=1 and 1<=block_num<=32; otherwise start SHALL be ignored.
REQ-004 The module SHALL ignore start while busy=1.
REQ-005 Beat order SHALL be the DC coefficient of blocks 0..N-1, then for scan position p=1..63 the coefficient of blocks 0..N-1 at raster index SCAN[p].
REQ-006 The source word for block b at scan position p SHALL be input_data[b*64 + SCAN[p]], computed with 11-bit address arithmetic.
REQ-007 The first beat SHALL present out_valid=1 in the cycle after start is accepted.
REQ-008 A beat SHALL advance only when out_valid&&out_ready; otherwise out_data, out_is_dc and out_last SHALL hold stable.
REQ-009 Consecutive beats SHALL be presented back-to-back (one per cycle) while out_ready=1.
REQ-010 The block index SHALL wrap from N-1 to 0 and increment p; DC SHALL go to AC when p becomes 1.
REQ-011 out_last SHALL be 1 only on the beat with b=N-1 and p=63; its acceptance SHALL move the state to FLUSH.
REQ-012 FLUSH SHALL pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-013 A start that coincides with the done cycle SHALL be ignored.
REQ-014 busy SHALL be 1 in DC, AC and FLUSH.
REQ-015 The total beat count per slice SHALL equal N*64.
REQ-016 input_data SHALL be held stable by the producer while busy=1; the module SHALL NOT register the whole memory.

Reset
REQ-017 When reset_n=0, the module SHALL asynchronously clear the state to IDLE and clear all counters.
REQ-018 When reset_n=0, out_data SHALL be 0, and out_valid, out_is_dc, out_last, busy and done SHALL all be 0.
REQ-019 A reset asserted mid-slice SHALL abandon the slice; after reset release, no beat SHALL be emitted until a new start is accepted.

Configuration
REQ-020 With SCAN_INTERLACED_EN defined, SCAN SHALL be the ProRes interlaced table (prefix 0,8,1,9,16,24,17,25).
REQ-021 Without SCAN_INTERLACED_EN, SCAN SHALL be the ProRes progressive table (prefix 0,1,8,9,2,3,10,11).
REQ-022 SCAN_INTERLACED_EN SHALL alter nothing except the table selection.

Structure
REQ-023 Package prores_scan_pkg SHALL hold MEM_WORDS=2048, BLOCK_WORDS=64, MAX_BLOCKS=32, both 64-entry scan tables and the state enum.
REQ-024 A sub-module coef_scan_addr SHALL map (block index, scan position) to an 11-bit word address combinationally.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Full slice: input_data[i]=i, N=2, out_ready=1, progressive -> beats 0,64 (is_dc=1), then 1,65,8,72,9,73; 128 beats total; last beat 127 with out_last=1; done pulses one cycle later.
- Back-pressure: N=1, out_ready toggles 1/0 each cycle -> the beat sequence is identical to the out_ready=1 run; out_data is stable while out_ready=0; 64 beats total.
- Illegal start: start with block_num=0, then with block_num=33 -> busy stays 0 and no beat is emitted; start while busy -> the stream is unchanged.
- Maximum slice: N=32 -> 2048 beats; the 32nd beat is 1984 (last DC); out_last is on beat 2048 only.
- Reset mid-slice: reset_n pulsed low after 10 beats -> all outputs are 0 immediately; no beats are emitted until a new start, which restarts at beat 0.
- Interlaced build: SCAN_INTERLACED_EN defined, N=1, input_data[i]=i -> beats 0,8,1,9,16,24.
